// File: rtl/mux_nto1_wh.sv
`default_nettype none
// ============================================================================
//  Module   : mux_nto1_wh
//  Purpose  : N-to-1 wormhole output multiplexer for one NoC router output
//             port. HEAD flits are arbitrated round-robin. The grant is held
//             until the TAIL flit has been forwarded. Flits leave through a
//             registered output stage with valid/ready backpressure.
//  Params   : NPORT (2..16) input ports, DATAW flit width (type field in
//             [DATAW-1:DATAW-2]), VCHW virtual-channel id width.
//  Ports    : clk, rst_ (async, active-high)
//             idata/ivalid/ivch  - per-port input flits, port i at slice i
//             iready             - per-port flit accepted this cycle
//             odata/ovalid/ovch  - registered output flit, oready from sink
//             grant              - one-hot current owner, zero when idle
//             busy               - high while a packet holds the output
//             fcnt               - saturating count of accepted flits
//                                  (present only with MUX_FLIT_CNT_EN)
//  Options  : `define MUX_FLIT_CNT_EN to add the fcnt energy counter.
//  Revision : 1.0 - initial release
// ============================================================================
module mux_nto1_wh #(
    parameter int NPORT = 5,
    parameter int DATAW = 66,
    parameter int VCHW  = 2
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic [NPORT*DATAW-1:0] idata,
    input  logic [NPORT-1:0]       ivalid,
    input  logic [NPORT*VCHW-1:0]  ivch,
    output logic [NPORT-1:0]       iready,
    output logic [DATAW-1:0]       odata,
    output logic                   ovalid,
    output logic [VCHW-1:0]        ovch,
    input  logic                   oready,
    output logic [NPORT-1:0]       grant,
    output logic                   busy
`ifdef MUX_FLIT_CNT_EN
    ,
    output logic [31:0]            fcnt
`endif
);

    localparam int         PW      = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam logic [1:0] FT_HEAD = 2'b01;
    localparam logic [1:0] FT_TAIL = 2'b11;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    logic [0:0]       state;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    gidx;
    logic [NPORT-1:0] req;
    logic             win_found;
    logic [PW-1:0]    win_idx;
    logic [DATAW-1:0] gdata;
    logic [VCHW-1:0]  gvch;
    logic             gvalid;
    logic             xfer;

    // Only a valid HEAD flit may open a new packet.
    genvar i;
    generate
        for (i = 0; i < NPORT; i++) begin : g_req
            assign req[i] = ivalid[i] & (idata[i*DATAW + DATAW-1 -: 2] == FT_HEAD);
        end
    endgenerate

    // Round-robin scan starting just above the last owner, so the port that
    // finished most recently is examined last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NPORT; k++) begin
            if (!win_found && req[(int'(rr_ptr) + k) % NPORT]) begin
                win_found = 1'b1;
                win_idx   = PW'((int'(rr_ptr) + k) % NPORT);
            end
        end
    end

    // grant is one-hot (or zero), so an AND-OR mux selects the owner.
    always_comb begin
        gdata  = '0;
        gvch   = '0;
        gvalid = 1'b0;
        for (int p = 0; p < NPORT; p++) begin
            if (grant[p]) begin
                gdata  = gdata | idata[p*DATAW +: DATAW];
                gvch   = gvch  | ivch[p*VCHW +: VCHW];
                gvalid = gvalid | ivalid[p];
            end
        end
    end

    // Accept a flit only when the output register is empty or draining.
    assign xfer   = (state == S_LOCKED) & gvalid & (~ovalid | oready);
    assign iready = grant & {NPORT{xfer}};

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state  <= S_IDLE;
            rr_ptr <= PW'(NPORT - 1);
            gidx   <= '0;
            grant  <= '0;
            busy   <= 1'b0;
            odata  <= '0;
            ovch   <= '0;
            ovalid <= 1'b0;
        end else begin
            if (xfer) begin
                odata  <= gdata;
                ovch   <= gvch;
                ovalid <= 1'b1;
            end else if (oready) begin
                ovalid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        state <= S_LOCKED;
                        gidx  <= win_idx;
                        grant <= {{(NPORT-1){1'b0}}, 1'b1} << win_idx;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    if (xfer && (gdata[DATAW-1 -: 2] == FT_TAIL)) begin
                        state  <= S_IDLE;
                        grant  <= '0;
                        busy   <= 1'b0;
                        rr_ptr <= gidx;
                    end
                end
            endcase
        end
    end

`ifdef MUX_FLIT_CNT_EN
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            fcnt <= '0;
        end else if (xfer && (fcnt != 32'hFFFF_FFFF)) begin
            fcnt <= fcnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_nto1_wh.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_nto1_wh
//  Purpose  : Self-checking bench for mux_nto1_wh (NPORT=5). A cycle table
//             covers idle stalls, arbitration and backpressure; packet
//             sources with a scoreboard cover single packet, round-robin,
//             backpressure, reset mid-packet and a long multi-packet run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_nto1_wh;

    localparam int NPORT = 5;
    localparam int DATAW = 66;
    localparam int VCHW  = 2;

    localparam logic [1:0] HEAD = 2'b01;
    localparam logic [1:0] DATA = 2'b10;
    localparam logic [1:0] TAIL = 2'b11;

    logic                   clk;
    logic                   rst_;
    logic [NPORT*DATAW-1:0] idata;
    logic [NPORT-1:0]       ivalid;
    logic [NPORT*VCHW-1:0]  ivch;
    logic [NPORT-1:0]       iready;
    logic [DATAW-1:0]       odata;
    logic                   ovalid;
    logic [VCHW-1:0]        ovch;
    logic                   oready;
    logic [NPORT-1:0]       grant;
    logic                   busy;
`ifdef MUX_FLIT_CNT_EN
    logic [31:0]            fcnt;
`endif

    mux_nto1_wh #(.NPORT(NPORT), .DATAW(DATAW), .VCHW(VCHW)) dut (
        .clk    (clk),
        .rst_   (rst_),
        .idata  (idata),
        .ivalid (ivalid),
        .ivch   (ivch),
        .iready (iready),
        .odata  (odata),
        .ovalid (ovalid),
        .ovch   (ovch),
        .oready (oready),
        .grant  (grant),
        .busy   (busy)
`ifdef MUX_FLIT_CNT_EN
        ,
        .fcnt   (fcnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- cycle table ----------------
    typedef struct packed {
        logic [4:0] v;     // ivalid
        logic [9:0] ty;    // flit type per port, port p at [2p+1:2p]
        logic       ordy;  // oready
        logic [4:0] g;     // expected grant
        logic       b;     // expected busy
        logic [4:0] ir;    // expected iready
        logic       ov;    // expected ovalid
        logic [1:0] ot;    // expected odata type field
        logic [1:0] oc;    // expected ovch
    } vec_t;

    vec_t tbl[12];

    // ---------------- packet sources + scoreboard ----------------
    typedef struct {
        logic [DATAW-1:0] d;
        logic [VCHW-1:0]  c;
    } flit_t;

    flit_t            expq[$];
    logic [NPORT-1:0] glog[$];
    logic [NPORT-1:0] prev_grant;
    int src_cnt[NPORT];
    int src_len[NPORT];
    int src_idx[NPORT];
    int src_pkt[NPORT];
    logic oready_drv;
    logic owned;
    int   owner;
    int   nout, cyc, first_out, last_out;
    logic [NPORT-1:0] s_grant, s_iready;
    logic             s_busy, s_ovalid;
    logic [DATAW-1:0] s_odata;

    function automatic logic [DATAW-1:0] mkflit(int p, int pk, int k, int len);
        logic [1:0] t;
        t = (k == 0) ? HEAD : ((k == len - 1) ? TAIL : DATA);
        return {t, 32'hA5A5_0000 | 32'(pk), 16'(p), 16'(k)};
    endfunction

    task automatic drive();
        for (int p = 0; p < NPORT; p++) begin
            if (src_cnt[p] > 0) begin
                ivalid[p] = 1'b1;
                idata[p*DATAW +: DATAW] = mkflit(p, src_pkt[p], src_idx[p], src_len[p]);
            end else begin
                ivalid[p] = 1'b0;
                idata[p*DATAW +: DATAW] = '0;
            end
            ivch[p*VCHW +: VCHW] = 2'(p);
        end
        oready = oready_drv;
    endtask

    // Sample at the falling edge, update scoreboard, end just after the rise.
    task automatic cycle();
        flit_t      f;
        logic [1:0] ty;
        @(negedge clk);
        s_grant  = grant;
        s_iready = iready;
        s_busy   = busy;
        s_ovalid = ovalid;
        s_odata  = odata;
        if (ovalid && oready) begin
            if (expq.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL out_unexpected: got %0h expected no flit", odata);
            end else begin
                f = expq.pop_front();
                chk("odata", odata, f.d);
                chk("ovch", ovch, f.c);
            end
            if (nout == 0) first_out = cyc;
            last_out = cyc;
            nout++;
        end
        chk("iready_onehot", ($countones(iready) <= 1), 1'b1);
        for (int p = 0; p < NPORT; p++) begin
            if (iready[p]) begin
                chk("iready_needs_valid", ivalid[p], 1'b1);
                ty = idata[p*DATAW + DATAW-2 +: 2];
                if (ty == HEAD) begin
                    chk("head_while_owned", owned, 1'b0);
                    owned = 1'b1;
                    owner = p;
                end else begin
                    chk("flit_without_head", owned, 1'b1);
                    chk("interleaved_port", p, owner);
                    if (ty == TAIL) owned = 1'b0;
                end
                f.d = idata[p*DATAW +: DATAW];
                f.c = ivch[p*VCHW +: VCHW];
                expq.push_back(f);
                src_idx[p]++;
                if (src_idx[p] == src_len[p]) begin
                    src_idx[p] = 0;
                    src_pkt[p]++;
                    src_cnt[p]--;
                end
            end
        end
        if (grant != '0 && prev_grant == '0) glog.push_back(grant);
        prev_grant = grant;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ = 1'b1;
        for (int p = 0; p < NPORT; p++) begin
            src_cnt[p] = 0;
            src_len[p] = 1;
            src_idx[p] = 0;
            src_pkt[p] = 0;
        end
        oready_drv = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst_ = 1'b0;
        expq.delete();
        glog.delete();
        prev_grant = '0;
        owned      = 1'b0;
        owner      = -1;
        nout       = 0;
        cyc        = 0;
        first_out  = -1;
        last_out   = -1;
    endtask

    initial begin
        rst_   = 1'b1;
        idata  = '0;
        ivalid = '0;
        ivch   = '0;
        oready = 1'b1;

        //            v        ty              ordy  g        b     ir       ov    ot     oc
        tbl[0]  = '{5'b01000, 10'b00_10_00_00_00, 1'b1, 5'b00000, 1'b0, 5'b00000, 1'b0, 2'b00, 2'd0};
        tbl[1]  = '{5'b01000, 10'b00_10_00_00_00, 1'b1, 5'b00000, 1'b0, 5'b00000, 1'b0, 2'b00, 2'd0};
        tbl[2]  = '{5'b01000, 10'b00_01_00_00_00, 1'b1, 5'b00000, 1'b0, 5'b00000, 1'b0, 2'b00, 2'd0};
        tbl[3]  = '{5'b01000, 10'b00_01_00_00_00, 1'b1, 5'b01000, 1'b1, 5'b01000, 1'b0, 2'b00, 2'd0};
        tbl[4]  = '{5'b01001, 10'b00_11_00_00_01, 1'b1, 5'b01000, 1'b1, 5'b01000, 1'b1, 2'b01, 2'd3};
        tbl[5]  = '{5'b00001, 10'b00_00_00_00_01, 1'b1, 5'b00000, 1'b0, 5'b00000, 1'b1, 2'b11, 2'd3};
        tbl[6]  = '{5'b00001, 10'b00_00_00_00_01, 1'b1, 5'b00001, 1'b1, 5'b00001, 1'b0, 2'b11, 2'd3};
        tbl[7]  = '{5'b00001, 10'b00_00_00_00_11, 1'b0, 5'b00001, 1'b1, 5'b00000, 1'b1, 2'b01, 2'd0};
        tbl[8]  = '{5'b00001, 10'b00_00_00_00_11, 1'b0, 5'b00001, 1'b1, 5'b00000, 1'b1, 2'b01, 2'd0};
        tbl[9]  = '{5'b00001, 10'b00_00_00_00_11, 1'b1, 5'b00001, 1'b1, 5'b00001, 1'b1, 2'b01, 2'd0};
        tbl[10] = '{5'b00000, 10'b00_00_00_00_00, 1'b1, 5'b00000, 1'b0, 5'b00000, 1'b1, 2'b11, 2'd0};
        tbl[11] = '{5'b00000, 10'b00_00_00_00_00, 1'b1, 5'b00000, 1'b0, 5'b00000, 1'b0, 2'b11, 2'd0};

        // Reset values while reset is held.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_odata", odata, '0);
        chk("rst_ovalid", ovalid, 1'b0);
        chk("rst_ovch", ovch, '0);
        chk("rst_grant", grant, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_iready", iready, '0);
        rst_ = 1'b0;

        // Cycle table: stray DATA in idle, arbitration, stalled loser, backpressure.
        for (int i = 0; i < 12; i++) begin
            ivalid = tbl[i].v;
            for (int p = 0; p < NPORT; p++) begin
                idata[p*DATAW +: DATAW] = {tbl[i].ty[2*p +: 2], 64'(p)};
                ivch[p*VCHW +: VCHW]    = 2'(p);
            end
            oready = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("tbl%0d_grant", i), grant, tbl[i].g);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].b);
            chk($sformatf("tbl%0d_iready", i), iready, tbl[i].ir);
            chk($sformatf("tbl%0d_ovalid", i), ovalid, tbl[i].ov);
            chk($sformatf("tbl%0d_otype", i), odata[DATAW-1 -: 2], tbl[i].ot);
            chk($sformatf("tbl%0d_ovch", i), ovch, tbl[i].oc);
            @(posedge clk);
            #1;
        end

        // Single packet: port 1, HEAD + 20 DATA + TAIL.
        do_reset();
        src_cnt[1] = 1;
        src_len[1] = 22;
        for (int c = 0; c < 30; c++) begin
            drive();
            cycle();
            if (c == 0) chk("single_grant_c0", s_grant, 5'b00000);
            if (c == 1) chk("single_grant_c1", s_grant, 5'b00010);
            if (c == 22) begin
                chk("single_tail_iready", s_iready, 5'b00010);
                chk("single_busy_at_tail", s_busy, 1'b1);
            end
            if (c == 23) chk("single_busy_after_tail", s_busy, 1'b0);
        end
        chk("single_nout", nout, 22);
        chk("single_first_out", first_out, 2);
        chk("single_last_out", last_out, 23);
        chk("single_q_empty", expq.size(), 0);

        // Round-robin: ports 0, 2, 4 each send two 3-flit packets.
        do_reset();
        foreach (src_cnt[p]) begin
            if (p == 0 || p == 2 || p == 4) begin
                src_cnt[p] = 2;
                src_len[p] = 3;
            end
        end
        for (int c = 0; c < 32; c++) begin
            drive();
            cycle();
        end
        chk("rr_ngrants", glog.size(), 6);
        if (glog.size() >= 4) begin
            chk("rr_grant0", glog[0], 5'b00001);
            chk("rr_grant1", glog[1], 5'b00100);
            chk("rr_grant2", glog[2], 5'b10000);
            chk("rr_grant3", glog[3], 5'b00001);
        end
        chk("rr_nout", nout, 18);
        chk("rr_q_empty", expq.size(), 0);

        // Backpressure: oready low for cycles 8..10 mid-packet on port 2.
        do_reset();
        src_cnt[2] = 1;
        src_len[2] = 22;
        begin
            logic [DATAW-1:0] hold;
            hold = '0;
            for (int c = 0; c < 35; c++) begin
                oready_drv = !(c >= 8 && c <= 10);
                drive();
                cycle();
                if (c == 8) begin
                    hold = s_odata;
                    chk("bp_ovalid", s_ovalid, 1'b1);
                end
                if (c >= 8 && c <= 10) chk($sformatf("bp_iready_c%0d", c), s_iready[2], 1'b0);
                if (c >= 9 && c <= 11) chk($sformatf("bp_odata_hold_c%0d", c), s_odata, hold);
            end
        end
        chk("bp_nout", nout, 22);
        chk("bp_q_empty", expq.size(), 0);

        // Reset mid-packet after 5 flits out, then port 0 must win first.
        do_reset();
        src_cnt[1] = 1;
        src_len[1] = 22;
        for (int c = 0; c < 40 && nout < 5; c++) begin
            drive();
            cycle();
        end
        chk("rstmid_nout_before", nout, 5);
        #2;
        rst_ = 1'b1;
        #1;
        chk("rstmid_ovalid", ovalid, 1'b0);
        chk("rstmid_grant", grant, '0);
        chk("rstmid_busy", busy, 1'b0);
        do_reset();
        src_cnt[0] = 1;
        src_len[0] = 3;
        src_cnt[1] = 1;
        src_len[1] = 3;
        for (int c = 0; c < 14; c++) begin
            drive();
            cycle();
        end
        chk("rstmid_ngrants", glog.size(), 2);
        if (glog.size() >= 1) chk("rstmid_first_grant", glog[0], 5'b00001);
        chk("rstmid_nout_after", nout, 6);

        // Long run: 10 packets of 22 flits on port 4.
        do_reset();
        src_cnt[4] = 10;
        src_len[4] = 22;
        for (int c = 0; c < 260; c++) begin
            drive();
            cycle();
        end
        chk("long_nout", nout, 220);
        chk("long_q_empty", expq.size(), 0);
`ifdef MUX_FLIT_CNT_EN
        chk("long_fcnt", fcnt, 32'd220);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
